hash160_host_driver: RTL and testbench
======================================

// Module: hash160_host_driver
// PURPOSE
//  Host-side driver for the Hash160 core's byte-in / word-out interface.
//  - Accepts one 512-bit pre-padded message block per job.
//  - Serializes the block to the core as 64 consecutive bytes.
//  - Collects the core's 16-bit answer words and reassembles the 160-bit digest.
//  - Sits between the test/system controller and the hash core top.
// PARAMETERS
//  N_BYTES      64    bytes sent per job; byte k = job_block[511-8k -: 8]
//  N_WORDS      10    answer words per digest, MSB word first (10 x 16 = 160)
//  TIMEOUT_CYC  4096  max cycles in WAIT+COLLECT (only with HASH160_HOST_TIMEOUT_EN)
// PORTS
//  clk          in   1    system clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  job_valid    in   1    job request
//  job_ready    out  1    high in IDLE only; job accepted when job_valid & job_ready
//  job_block    in   512  message block, byte 0 in [511:504]; sampled at accept
//  h_valid      out  1    to core i_valid; high on every SEND byte cycle
//  h_text       out  8    to core i_text; current byte
//  h_ans_valid  in   1    from core o_valid
//  h_ans        in   16   from core o_answer
//  busy         out  1    state != IDLE
//  digest_valid out  1    1-cycle pulse when digest is complete
//  digest       out  160  assembled digest; held until next completion
//  err_timeout  out  1    1-cycle pulse on watchdog expiry (0 when feature is off)
// BEHAVIOUR
//  - Reset: state=IDLE; job_ready=1; h_valid=0; h_text=0; busy=0;
//    digest_valid=0; digest=0; err_timeout=0; all counters 0.
//  - All outputs registered.
//  - IDLE: on accept, latch job_block and set byte_cnt=0 -> SEND.
//  - SEND:
//    - First byte appears the cycle after accept: h_valid=1, h_text=byte 0.
//    - byte_cnt increments each cycle; bytes 0..63 on 64 back-to-back cycles.
//    - No gaps: the core samples a byte every cycle once h_valid rises.
//    - After byte 63, h_valid=0 -> WAIT.
//    - h_ans_valid during SEND is ignored.
//  - WAIT / COLLECT:
//    - On each h_ans_valid: digest_shift <= {digest_shift[143:0], h_ans}; word_cnt++.
//    - The first word moves WAIT -> COLLECT.
//    - Gaps in h_ans_valid are tolerated; the state is held.
//    - On the cycle the 10th word is taken: next cycle digest <= assembled value,
//      digest_valid=1 for 1 cycle, state -> IDLE (job_ready=1 in that same cycle).
//    - Words arriving in IDLE, or beyond the 10th, are ignored.
//  - Latency:
//    - Accept to first byte: 1 cycle.
//    - Accept to h_valid falling: 65 cycles.
//    - 10th word to digest_valid: 1 cycle.
//  - job_valid while busy: not accepted and not queued; the requester must hold it.
//  - Reset mid-operation: immediate return to reset values; a partial digest
//    is discarded and the digest output is cleared.
//  - Counters: byte_cnt 7 bits, word_cnt 4 bits, both cleared at each accept.
//    No wrap occurs; termination is on ==63 and ==9.
// CONFIGURATION
//  HASH160_HOST_TIMEOUT_EN defined:
//    - A 16-bit watchdog clears at SEND->WAIT and counts every cycle in WAIT/COLLECT.
//    - On reaching TIMEOUT_CYC: err_timeout pulses 1 cycle, digest_valid stays 0,
//      digest keeps its old value, state -> IDLE.
//    - If the 10th word and expiry land on the same cycle, completion wins.
//  HASH160_HOST_TIMEOUT_EN undefined:
//    - No watchdog; WAIT/COLLECT waits indefinitely.
//    - err_timeout tied to 0; the port is kept.
// TESTING
//  1 Reset: assert rst_n=0 mid-SEND -> h_valid=0, busy=0, job_ready=1,
//    digest=0 within the reset; no further bytes sent.
//  2 Serialize: job_block with byte k = k (0x00..0x3F) -> h_text 0x00..0x3F
//    on 64 consecutive h_valid cycles starting 1 cycle after accept.
//  3 Collect: after SEND, drive 10 back-to-back words 0x0001..0x000A ->
//    digest = 160'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A;
//    digest_valid 1 cycle later for exactly 1 cycle.
//  4 Gapped answer: same 10 words with 3 idle cycles inserted after word 4 ->
//    identical digest; h_ans_valid pulse during SEND or an 11th word -> ignored.
//  5 Busy reject / back-to-back: job_valid held through a job -> second job
//    accepted on the digest_valid cycle; its first byte follows 1 cycle later.
//  6 Timeout (HASH160_HOST_TIMEOUT_EN, TIMEOUT_CYC=16): no answer words ->
//    err_timeout pulse 16 cycles after SEND ends, digest unchanged, IDLE.

Source files
------------

// File: rtl/hash160_host_driver_if.sv
// Bundle of job, core-facing and digest signals for the Hash160 host driver.
// master = controller/testbench side, slave = the driver itself.
interface hash160_host_driver_if;
    logic         job_valid;
    logic         job_ready;
    logic [511:0] job_block;
    logic         h_valid;
    logic [7:0]   h_text;
    logic         h_ans_valid;
    logic [15:0]  h_ans;
    logic         busy;
    logic         digest_valid;
    logic [159:0] digest;
    logic         err_timeout;

    modport master (
        output job_valid, job_block, h_ans_valid, h_ans,
        input  job_ready, h_valid, h_text, busy, digest_valid, digest, err_timeout
    );

    modport slave (
        input  job_valid, job_block, h_ans_valid, h_ans,
        output job_ready, h_valid, h_text, busy, digest_valid, digest, err_timeout
    );
endinterface

// File: rtl/hash160_host_driver.sv
// Serializes a 512-bit block to the Hash160 core byte by byte and reassembles
// the 160-bit digest from 16-bit answer words. Optional watchdog: HASH160_HOST_TIMEOUT_EN.
module hash160_host_driver #(
    parameter int N_BYTES     = 64,
    parameter int N_WORDS     = 10,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hash160_host_driver_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, COLLECT} state_t;

    localparam logic [6:0] LAST_BYTE = 7'(N_BYTES - 1);
    localparam logic [3:0] LAST_WORD = 4'(N_WORDS - 1);

    state_t         state;
    logic [503:0]   block_q;
    logic [6:0]     byte_cnt;
    logic [3:0]     word_cnt;
    logic [143:0]   digest_shift;
    logic           job_ready_q;
    logic           h_valid_q;
    logic [7:0]     h_text_q;
    logic           busy_q;
    logic           digest_valid_q;
    logic [159:0]   digest_q;
    logic           err_timeout_q;

`ifdef HASH160_HOST_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wdog;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    // Only nine words are buffered; the tenth goes straight into the digest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            block_q        <= '0;
            byte_cnt       <= '0;
            word_cnt       <= '0;
            digest_shift   <= '0;
            job_ready_q    <= 1'b1;
            h_valid_q      <= 1'b0;
            h_text_q       <= '0;
            busy_q         <= 1'b0;
            digest_valid_q <= 1'b0;
            digest_q       <= '0;
            err_timeout_q  <= 1'b0;
`ifdef HASH160_HOST_TIMEOUT_EN
            wdog           <= '0;
`endif
        end else begin
            digest_valid_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.job_valid) begin
                        h_text_q     <= bus.job_block[511:504];
                        block_q      <= bus.job_block[503:0];
                        h_valid_q    <= 1'b1;
                        byte_cnt     <= '0;
                        word_cnt     <= '0;
                        digest_shift <= '0;
                        job_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (byte_cnt == LAST_BYTE) begin
                        h_valid_q <= 1'b0;
                        h_text_q  <= '0;
                        state     <= WAIT;
`ifdef HASH160_HOST_TIMEOUT_EN
                        wdog      <= '0;
`endif
                    end else begin
                        byte_cnt <= byte_cnt + 7'd1;
                        h_text_q <= block_q[503:496];
                        block_q  <= {block_q[495:0], 8'h00};
                    end
                end
                WAIT, COLLECT: begin
                    if (bus.h_ans_valid) begin
                        digest_shift <= {digest_shift[127:0], bus.h_ans};
                        word_cnt     <= word_cnt + 4'd1;
                        if (word_cnt == LAST_WORD) begin
                            digest_q       <= {digest_shift, bus.h_ans};
                            digest_valid_q <= 1'b1;
                            job_ready_q    <= 1'b1;
                            busy_q         <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            state <= COLLECT;
                        end
                    end
`ifdef HASH160_HOST_TIMEOUT_EN
                    // Completion on the expiry cycle takes priority over the timeout.
                    if (!(bus.h_ans_valid && word_cnt == LAST_WORD)) begin
                        if (wdog == WDOG_LAST) begin
                            err_timeout_q <= 1'b1;
                            job_ready_q   <= 1'b1;
                            busy_q        <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            wdog <= wdog + 16'd1;
                        end
                    end
`endif
                end
            endcase
        end
    end

    assign bus.job_ready    = job_ready_q;
    assign bus.h_valid      = h_valid_q;
    assign bus.h_text       = h_text_q;
    assign bus.busy         = busy_q;
    assign bus.digest_valid = digest_valid_q;
    assign bus.digest       = digest_q;
    assign bus.err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_hash160_host_driver.sv
// Scoreboard bench for hash160_host_driver: stimulus queues expected bytes and
// digests, a negedge monitor pops and compares whatever the driver presents.
module tb_hash160_host_driver;

    logic clk;
    logic rst_n;
    hash160_host_driver_if bus ();

    hash160_host_driver #(.TIMEOUT_CYC(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int err_pulses   = 0;
    logic [7:0]   byte_q[$];
    logic [159:0] dig_q[$];

    task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] byte_of(input int kind, input int k);
        case (kind)
            0:       return 8'(k);
            1:       return 8'(255 - k);
            2:       return 8'(k * 3 + 5);
            3:       return 8'(k) ^ 8'h5A;
            default: return 8'(k + 128);
        endcase
    endfunction

    function automatic logic [159:0] expected_digest(input logic [15:0] mask);
        logic [159:0] d = '0;
        for (int i = 0; i < 10; i++) d = {d[143:0], 16'(i + 1) ^ mask};
        return d;
    endfunction

    task automatic build_job(input int kind, output logic [511:0] blk);
        blk = '0;
        for (int k = 0; k < 64; k++) begin
            blk[511 - 8 * k -: 8] = byte_of(kind, k);
            byte_q.push_back(byte_of(kind, k));
        end
    endtask

    // Returns one tick after the accepting edge; hold leaves job_valid asserted.
    task automatic applyStimulus(input int kind, input bit hold);
        logic [511:0] blk;
        int waited = 0;
        build_job(kind, blk);
        @(negedge clk);
        while (!bus.job_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("job_ready_wait", 160'(bus.job_ready), 160'd1);
        bus.job_valid = 1'b1;
        bus.job_block = blk;
        @(posedge clk);
        #1;
        if (!hold) bus.job_valid = 1'b0;
    endtask

    // Watches the SEND burst; optionally injects a stray answer word mid-burst.
    task automatic run_send(input int inject);
        int cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == inject) begin
                bus.h_ans_valid = 1'b1;
                bus.h_ans       = 16'hDEAD;
            end else begin
                bus.h_ans_valid = 1'b0;
            end
            if (i == 0) checkOutput("first_byte_latency", 160'(bus.h_valid), 160'd1);
            if (!bus.h_valid) break;
            cnt++;
        end
        bus.h_ans_valid = 1'b0;
        checkOutput("send_length", 160'(cnt), 160'd64);
    endtask

    // Ends on the negedge following the edge that takes the tenth word.
    task automatic drive_words(input logic [15:0] mask, input int gap_after, input int gap_len);
        for (int i = 0; i < 10; i++) begin
            if (i == gap_after) begin
                bus.h_ans_valid = 1'b0;
                repeat (gap_len) @(negedge clk);
            end
            bus.h_ans_valid = 1'b1;
            bus.h_ans       = 16'(i + 1) ^ mask;
            @(negedge clk);
        end
        bus.h_ans_valid = 1'b0;
    endtask

    task automatic check_completion(input string tag);
        checkOutput({tag, "_dv_latency"}, 160'(bus.digest_valid), 160'd1);
        checkOutput({tag, "_ready_on_done"}, 160'(bus.job_ready), 160'd1);
        checkOutput({tag, "_busy_on_done"}, 160'(bus.busy), 160'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.h_valid) begin
                if (byte_q.size() == 0) checkOutput("unexpected_byte", 160'(bus.h_text), 160'hFFFF);
                else checkOutput("h_text", 160'(bus.h_text), 160'(byte_q.pop_front()));
            end
            if (bus.digest_valid) begin
                if (dig_q.size() == 0) checkOutput("unexpected_digest", bus.digest, '1);
                else checkOutput("digest", bus.digest, dig_q.pop_front());
            end
            if (bus.err_timeout) err_pulses++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL sim_time_limit: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int low_cnt;
        rst_n           = 1'b0;
        bus.job_valid   = 1'b0;
        bus.job_block   = '0;
        bus.h_ans_valid = 1'b0;
        bus.h_ans       = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_job_ready", 160'(bus.job_ready), 160'd1);
        checkOutput("rst_h_valid", 160'(bus.h_valid), 160'd0);
        checkOutput("rst_h_text", 160'(bus.h_text), 160'd0);
        checkOutput("rst_busy", 160'(bus.busy), 160'd0);
        checkOutput("rst_digest", bus.digest, 160'd0);
        checkOutput("rst_err_timeout", 160'(bus.err_timeout), 160'd0);
        rst_n = 1'b1;

        $display("[TB] serialize and collect");
        applyStimulus(0, 1'b0);
        run_send(-1);
        dig_q.push_back(160'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A);
        drive_words(16'h0000, 99, 0);
        check_completion("collect");
        @(negedge clk);
        checkOutput("dv_single_cycle", 160'(bus.digest_valid), 160'd0);

        $display("[TB] gapped answer, stray words");
        applyStimulus(1, 1'b0);
        run_send(10);
        dig_q.push_back(160'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A);
        drive_words(16'h0000, 4, 3);
        check_completion("gapped");
        bus.h_ans_valid = 1'b1;
        bus.h_ans       = 16'h00BB;
        @(negedge clk);
        bus.h_ans_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("eleventh_word_digest", bus.digest, expected_digest(16'h0000));
        checkOutput("eleventh_word_busy", 160'(bus.busy), 160'd0);

        $display("[TB] stalled answer");
        applyStimulus(4, 1'b0);
        run_send(-1);
`ifdef HASH160_HOST_TIMEOUT_EN
        begin
            int lat = 0;
            for (int i = 1; i <= 100; i++) begin
                @(negedge clk);
                lat = i;
                if (bus.err_timeout) break;
            end
            checkOutput("timeout_latency", 160'(lat), 160'd16);
            checkOutput("timeout_no_dv", 160'(bus.digest_valid), 160'd0);
            checkOutput("timeout_digest_kept", bus.digest, expected_digest(16'h0000));
            checkOutput("timeout_idle", 160'(bus.job_ready), 160'd1);
            @(negedge clk);
            checkOutput("timeout_single_cycle", 160'(bus.err_timeout), 160'd0);
        end
`else
        repeat (40) @(negedge clk);
        checkOutput("stall_still_busy", 160'(bus.busy), 160'd1);
        checkOutput("stall_no_timeout", 160'(bus.err_timeout), 160'd0);
        dig_q.push_back(expected_digest(16'h1111));
        drive_words(16'h1111, 99, 0);
        check_completion("stall");
`endif

        $display("[TB] busy reject and back-to-back");
        applyStimulus(2, 1'b1);
        begin
            logic [511:0] blk2;
            build_job(3, blk2);
            bus.job_block = blk2;
        end
        run_send(-1);
        checkOutput("held_not_accepted", 160'(bus.job_ready), 160'd0);
        checkOutput("held_busy", 160'(bus.busy), 160'd1);
        dig_q.push_back(expected_digest(16'hA5C3));
        drive_words(16'hA5C3, 99, 0);
        check_completion("b2b");
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_first_byte", 160'(bus.h_valid), 160'd1);
        repeat (5) @(negedge clk);

        $display("[TB] reset mid-send");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        byte_q.delete();
        #1;
        checkOutput("midrst_h_valid", 160'(bus.h_valid), 160'd0);
        checkOutput("midrst_busy", 160'(bus.busy), 160'd0);
        checkOutput("midrst_job_ready", 160'(bus.job_ready), 160'd1);
        checkOutput("midrst_digest", bus.digest, 160'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        low_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.h_valid) low_cnt++;
        end
        checkOutput("post_reset_no_bytes", 160'(low_cnt), 160'd0);
        checkOutput("bytes_drained", 160'(byte_q.size()), 160'd0);
        checkOutput("digests_drained", 160'(dig_q.size()), 160'd0);
`ifdef HASH160_HOST_TIMEOUT_EN
        checkOutput("err_pulse_count", 160'(err_pulses), 160'd1);
`else
        checkOutput("err_pulse_count", 160'(err_pulses), 160'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
